// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: the prediction record held between fetch and EX.
package bru_pkg;
  localparam int BRU_DATA_WIDTH = 32;
  localparam int BRU_PC_STEP    = 4;

  typedef struct packed {
    logic [BRU_DATA_WIDTH-1:0] pc;
    logic                      taken;
    logic [BRU_DATA_WIDTH-1:0] target;
  } bru_pred_t;
endpackage

// File: rtl/bru_pred_fifo.sv
// In-order prediction queue with wrap-bit pointers. Clear retires the head and drops every younger entry.
module bru_pred_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  input  logic i_clear,
  output T     o_head,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  T            r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;
  logic [AW:0] w_rd_inc;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full && !i_clear;
  assign w_do_pop  = (i_pop || i_clear) && !o_empty;
  assign w_rd_inc  = r_rd_ptr + (AW+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear && !o_empty) begin
      // Head is consumed and everything behind it is wrong-path.
      r_rd_ptr <= w_rd_inc;
      r_wr_ptr <= w_rd_inc;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= w_rd_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Compares each resolved branch with its queued fetch-time prediction and issues redirect/flush.
// Optional BRU_STATS_EN adds saturating branch and mispredict counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DATA_WIDTH = BRU_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pred_valid,
  output logic                  pred_ready,
  input  logic [DATA_WIDTH-1:0] pred_pc,
  input  logic                  pred_taken,
  input  logic [DATA_WIDTH-1:0] pred_target,
  input  logic                  res_valid,
  input  logic                  res_taken,
  input  logic [DATA_WIDTH-1:0] res_target,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic                  underflow_err
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
`endif
);
  bru_pred_t             w_push_data;
  bru_pred_t             w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_resolve;
  logic                  w_mispredict;
  logic [DATA_WIDTH-1:0] w_fix_pc;

  logic                  r_redirect_valid;
  logic                  r_flush;
  logic [DATA_WIDTH-1:0] r_redirect_pc;
  logic                  r_underflow;

  assign w_push_data = '{pc: pred_pc, taken: pred_taken, target: pred_target};

  bru_pred_fifo #(.DEPTH(DEPTH), .T(bru_pred_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (pred_valid && pred_ready),
    .i_data  (w_push_data),
    .i_pop   (w_resolve),
    .i_clear (w_mispredict),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign pred_ready   = !w_full;
  assign w_resolve    = res_valid && !w_empty;
  assign w_mispredict = w_resolve &&
                        ((w_head.taken != res_taken) ||
                         (w_head.taken && res_taken && (w_head.target != res_target)));
  assign w_fix_pc     = res_taken ? res_target : (w_head.pc + DATA_WIDTH'(BRU_PC_STEP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_valid <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_pc    <= '0;
      r_underflow      <= 1'b0;
    end else begin
      r_redirect_valid <= w_mispredict;
      r_flush          <= w_mispredict;
      if (w_mispredict)          r_redirect_pc <= w_fix_pc;
      if (res_valid && w_empty)  r_underflow   <= 1'b1;
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign flush          = r_flush;
  assign redirect_pc    = r_redirect_pc;
  assign underflow_err  = r_underflow;

`ifdef BRU_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_resolve && (r_stat_branches != '1))       r_stat_branches    <= r_stat_branches + 32'd1;
      if (w_mispredict && (r_stat_mispredicts != '1)) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected redirects queued at issue, checked by a monitor.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pred_valid = 1'b0;
  logic        pred_ready;
  logic [31:0] pred_pc = '0;
  logic        pred_taken = 1'b0;
  logic [31:0] pred_target = '0;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        underflow_err;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_valid     (pred_valid),
    .pred_ready     (pred_ready),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .underflow_err  (underflow_err)
`ifdef BRU_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every redirect pulse must match the oldest queued expectation and carry flush.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (redirect_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_redirect: got pc 0x%0h required no redirect", redirect_pc);
          end else begin
            e = exp_q.pop_front();
            check("redirect_pc", redirect_pc, e);
            check("flush_with_redirect", {31'b0, flush}, 32'd1);
            $display("redirect observed pc=0x%0h expected 0x%0h", redirect_pc, e);
          end
        end else if (flush) begin
          check("flush_without_redirect", {31'b0, flush}, 32'd0);
        end
      end
    end
  end

  task automatic step(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptg,
                      input logic rv, input logic rt, input logic [31:0] rtg,
                      input logic exp_redir, input logic [31:0] exp_pc);
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
    if (exp_redir) exp_q.push_back(exp_pc);
    $display("txn pv=%0d pc=0x%0h pt=%0d ptg=0x%0h | rv=%0d rt=%0d rtg=0x%0h | exp_redir=%0d exp_pc=0x%0h",
             pv, ppc, pt, ptg, rv, rt, rtg, exp_redir, exp_pc);
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic enq(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    step(1'b1, pc, t, tg, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic res(input logic t, input logic [31:0] tg, input logic er, input logic [31:0] epc);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, t, tg, er, epc);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values while rst_n is held low
    #2;
    check("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_underflow", {31'b0, underflow_err}, 32'd0);
    check("rst_pred_ready", {31'b0, pred_ready}, 32'd1);
    @(posedge clk); #1; rst_n = 1'b1;

    // 1: correct taken prediction
    enq(32'h100, 1'b1, 32'h140);
    res(1'b1, 32'h140, 1'b0, 32'h0);
    idle();
    check("t1_underflow", {31'b0, underflow_err}, 32'd0);

    // 2: predicted taken, actually not taken -> pc+4
    enq(32'h200, 1'b1, 32'h180);
    res(1'b0, 32'h0, 1'b1, 32'h204);
    idle(); idle();
    check("t2_underflow", {31'b0, underflow_err}, 32'd0);

    // 3: target mismatch flushes younger entries
    enq(32'h280, 1'b1, 32'h2F0);
    enq(32'h284, 1'b0, 32'h0);
    enq(32'h288, 1'b0, 32'h0);
    res(1'b1, 32'h300, 1'b1, 32'h300);
    idle();
    check("t3_ready_after_clear", {31'b0, pred_ready}, 32'd1);
    res(1'b0, 32'h0, 1'b0, 32'h0);
    check("t3_underflow_set", {31'b0, underflow_err}, 32'd1);
    idle();
    check("t3_underflow_sticky", {31'b0, underflow_err}, 32'd1);

    // 4: full queue back-pressure
    do_reset();
    enq(32'h400, 1'b0, 32'h0);
    enq(32'h404, 1'b0, 32'h0);
    enq(32'h408, 1'b0, 32'h0);
    check("t4_ready_three", {31'b0, pred_ready}, 32'd1);
    enq(32'h40C, 1'b0, 32'h0);
    check("t4_full_ready", {31'b0, pred_ready}, 32'd0);
    enq(32'h410, 1'b1, 32'h999);
    check("t4_still_full", {31'b0, pred_ready}, 32'd0);
    res(1'b0, 32'h0, 1'b0, 32'h0);
    check("t4_ready_after_pop", {31'b0, pred_ready}, 32'd1);
    res(1'b0, 32'h0, 1'b0, 32'h0);
    res(1'b0, 32'h0, 1'b0, 32'h0);
    res(1'b0, 32'h0, 1'b0, 32'h0);
    check("t4_no_underflow_yet", {31'b0, underflow_err}, 32'd0);
    res(1'b0, 32'h0, 1'b0, 32'h0);
    check("t4_fifth_dropped", {31'b0, underflow_err}, 32'd1);

    // 5a: enqueue in the same cycle as a mispredict is dropped
    do_reset();
    enq(32'h700, 1'b0, 32'h0);
    enq(32'h704, 1'b0, 32'h0);
    step(1'b1, 32'h708, 1'b0, 32'h0, 1'b1, 1'b1, 32'h780, 1'b1, 32'h780);
    idle();
    res(1'b0, 32'h0, 1'b0, 32'h0);
    check("t5_queue_cleared", {31'b0, underflow_err}, 32'd1);

    // 5b: asynchronous reset with a full queue
    enq(32'h720, 1'b0, 32'h0);
    enq(32'h724, 1'b0, 32'h0);
    enq(32'h728, 1'b0, 32'h0);
    enq(32'h72C, 1'b0, 32'h0);
    check("t5_full", {31'b0, pred_ready}, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_async_ready", {31'b0, pred_ready}, 32'd1);
    check("t5_async_underflow", {31'b0, underflow_err}, 32'd0);
    check("t5_async_redirect_pc", redirect_pc, 32'h0);
    check("t5_async_flush", {31'b0, flush}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    res(1'b0, 32'h0, 1'b0, 32'h0);
    check("t5_entries_discarded", {31'b0, underflow_err}, 32'd1);

    // 6: five resolutions, two mispredicts, including pc+4 wrap
    do_reset();
    enq(32'hA0, 1'b0, 32'h0);
    enq(32'hB0, 1'b1, 32'hC0);
    res(1'b0, 32'h0, 1'b0, 32'h0);
    res(1'b1, 32'hC0, 1'b0, 32'h0);
    enq(32'h800, 1'b0, 32'h0);
    res(1'b1, 32'h900, 1'b1, 32'h900);
    enq(32'hFFFF_FFFC, 1'b1, 32'h10);
    enq(32'hD00, 1'b0, 32'h0);
    res(1'b0, 32'h0, 1'b1, 32'h0);
    enq(32'hA00, 1'b1, 32'hA40);
    res(1'b1, 32'hA40, 1'b0, 32'h0);
    idle();
    check("t6_underflow", {31'b0, underflow_err}, 32'd0);
`ifdef BRU_STATS_EN
    check("t6_stat_branches", stat_branches, 32'd5);
    check("t6_stat_mispredicts", stat_mispredicts, 32'd2);
`endif

    idle(); idle();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
